// File: rtl/glyph_row_fetch.sv
// glyph_row_fetch: latches one character code, reads its glyph rows from the font ROM and
// streams them out in order through a 2-entry buffer that absorbs the ROM read latency.
module glyph_row_fetch #(
    parameter int unsigned ROWS   = 16,
    parameter int unsigned CODE_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           char_valid,
    output logic                           char_ready,
    input  logic [CODE_W-1:0]              char_code,
    output logic [CODE_W+$clog2(ROWS)-1:0] rom_ad,
    output logic                           rom_ce,
    output logic                           rom_oce,
    input  logic [DATA_W-1:0]              rom_dout,
    output logic                           row_valid,
    input  logic                           row_ready,
    output logic [DATA_W-1:0]              row_data,
    output logic [$clog2(ROWS)-1:0]        row_idx,
    output logic                           row_last,
    output logic                           busy
);
    localparam int unsigned RW = $clog2(ROWS);
    localparam logic [RW-1:0] LastRow = RW'(ROWS - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_t;

    state_t              r_state;
    state_t              w_state_d;
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   w_code_d;
    logic [RW-1:0]       r_issue_row;
    logic [RW-1:0]       w_issue_row_d;
    logic                r_inflight;
    logic [RW-1:0]       r_cap_idx;
    logic [1:0]          r_occ;
    logic [1:0]          w_occ_d;
    logic [DATA_W-1:0]   r_head_data;
    logic [DATA_W-1:0]   w_head_data_d;
    logic [RW-1:0]       r_head_idx;
    logic [RW-1:0]       w_head_idx_d;
    logic [DATA_W-1:0]   r_tail_data;
    logic [DATA_W-1:0]   w_tail_data_d;
    logic [RW-1:0]       r_tail_idx;
    logic [RW-1:0]       w_tail_idx_d;
    logic                w_issue;
    logic                w_pop;
    logic                w_push;
    logic [2:0]          w_pend;

    assign w_pop  = (r_occ != 2'd0) && row_ready;
    assign w_push = r_inflight;
    // Rows that will still be held or in flight after this cycle's pop.
    assign w_pend = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        w_state_d     = r_state;
        w_code_d      = r_code;
        w_issue_row_d = r_issue_row;
        w_issue       = 1'b0;
        case (r_state)
            StIdle: begin
                if (char_valid) begin
                    w_state_d     = StFetch;
                    w_code_d      = char_code;
                    w_issue_row_d = '0;
                end
            end
            StFetch: begin
                if (w_pend < 3'd2) begin
                    w_issue       = 1'b1;
                    w_issue_row_d = r_issue_row + RW'(1);
                    if (r_issue_row == LastRow) begin
                        w_state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (w_pend == 3'd0) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_occ_d       = r_occ;
        w_head_data_d = r_head_data;
        w_head_idx_d  = r_head_idx;
        w_tail_data_d = r_tail_data;
        w_tail_idx_d  = r_tail_idx;
        case ({w_push, w_pop})
            2'b10: begin
                if (r_occ == 2'd0) begin
                    w_head_data_d = rom_dout;
                    w_head_idx_d  = r_cap_idx;
                end else begin
                    w_tail_data_d = rom_dout;
                    w_tail_idx_d  = r_cap_idx;
                end
                w_occ_d = r_occ + 2'd1;
            end
            2'b01: begin
                w_head_data_d = r_tail_data;
                w_head_idx_d  = r_tail_idx;
                w_occ_d       = r_occ - 2'd1;
            end
            2'b11: begin
                if (r_occ == 2'd2) begin
                    w_head_data_d = r_tail_data;
                    w_head_idx_d  = r_tail_idx;
                    w_tail_data_d = rom_dout;
                    w_tail_idx_d  = r_cap_idx;
                end else begin
                    w_head_data_d = rom_dout;
                    w_head_idx_d  = r_cap_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_code      <= '0;
            r_issue_row <= '0;
            r_inflight  <= 1'b0;
            r_cap_idx   <= '0;
            r_occ       <= 2'd0;
            r_head_data <= '0;
            r_head_idx  <= '0;
            r_tail_data <= '0;
            r_tail_idx  <= '0;
        end else begin
            r_state     <= w_state_d;
            r_code      <= w_code_d;
            r_issue_row <= w_issue_row_d;
            r_inflight  <= w_issue;
            if (w_issue) begin
                r_cap_idx <= r_issue_row;
            end
            r_occ       <= w_occ_d;
            r_head_data <= w_head_data_d;
            r_head_idx  <= w_head_idx_d;
            r_tail_data <= w_tail_data_d;
            r_tail_idx  <= w_tail_idx_d;
        end
    end

    // Reset gates the request/read strobes so nothing is issued while state is being cleared.
    assign char_ready = (r_state == StIdle) && !reset;
    assign busy       = (r_state != StIdle);
    assign rom_ce     = w_issue && !reset;
    assign rom_ad     = rom_ce ? {r_code, r_issue_row} : '0;
    assign rom_oce    = 1'b1;
    assign row_valid  = (r_occ != 2'd0);
    assign row_data   = r_head_data;
    assign row_idx    = r_head_idx;
    assign row_last   = row_valid && (r_head_idx == LastRow);

endmodule
